// File: rtl/uart_fifo_loopback.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_loopback
// Brief    : UART echo engine. A receiver feeds a synchronous FIFO and a
//            transmitter drains it. The last good character drives led, and
//            overflow and framing errors are held in sticky flags.
//            Optional build macro UART_PARITY_EN adds one parity bit per frame
//            on both rx and tx. ODD_PARITY selects its sense.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_loopback #(
    parameter int CLK_PER_BIT = 4,
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int ODD_PARITY  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic                          tx,
    input  logic                          block,
    input  logic                          clear_err,
    output logic [DATA_BITS-1:0]          led,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int c_tw = $clog2(CLK_PER_BIT);
    localparam int c_bw = $clog2(DATA_BITS);
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = c_aw + 1;

    localparam logic [c_tw-1:0] c_half     = c_tw'(CLK_PER_BIT / 2);
    localparam logic [c_tw-1:0] c_last     = c_tw'(CLK_PER_BIT - 1);
    localparam logic [c_bw-1:0] c_bit_last = c_bw'(DATA_BITS - 1);
    localparam logic [c_cw-1:0] c_full     = c_cw'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
    localparam logic c_odd = (ODD_PARITY != 0);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic                  r_rx_meta, r_rx_sync;

    state_t                r_rx_state, w_rx_state_nxt;
    logic [c_tw-1:0]       r_rx_timer, w_rx_timer_nxt;
    logic [c_bw-1:0]       r_rx_bit,   w_rx_bit_nxt;
    logic [DATA_BITS-1:0]  r_rx_shift, w_rx_shift_nxt;
    logic                  w_rx_valid, w_rx_bad;

    state_t                r_tx_state, w_tx_state_nxt;
    logic [c_tw-1:0]       r_tx_timer, w_tx_timer_nxt;
    logic [c_bw-1:0]       r_tx_bit,   w_tx_bit_nxt;
    logic [DATA_BITS-1:0]  r_tx_shift, w_tx_shift_nxt;
    logic                  w_tx_line;
    logic                  r_tx;

`ifdef UART_PARITY_EN
    logic                  r_rx_par,   w_rx_par_nxt;
    logic                  r_tx_par,   w_tx_par_nxt;
    logic                  w_rx_par_ok;
`endif

    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]       r_wr_ptr, r_rd_ptr;
    logic [c_cw-1:0]       r_count;
    logic                  w_full, w_can_pop, w_push, w_pop, w_drop;
    logic [DATA_BITS-1:0]  w_head;

    logic [DATA_BITS-1:0]  r_led;
    logic                  r_overflow, r_frame_err;

    assign tx         = r_tx;
    assign led        = r_led;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign frame_err  = r_frame_err;

    // rx is asynchronous; bring it into the clk domain before any use
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
`ifdef UART_PARITY_EN
    assign w_rx_par_ok = (r_rx_par == ((^r_rx_shift) ^ c_odd));
`endif

    // RX state register and bit-timing datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= S_IDLE;
            r_rx_timer <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
`ifdef UART_PARITY_EN
            r_rx_par   <= 1'b0;
`endif
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_timer <= w_rx_timer_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
`ifdef UART_PARITY_EN
            r_rx_par   <= w_rx_par_nxt;
`endif
        end
    end

    // RX next state: start is re-checked at half a bit, later bits sampled a full bit apart
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_timer_nxt = r_rx_timer;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_valid     = 1'b0;
        w_rx_bad       = 1'b0;
`ifdef UART_PARITY_EN
        w_rx_par_nxt   = r_rx_par;
`endif
        case (r_rx_state)
            S_IDLE: begin
                if (!r_rx_sync) begin
                    w_rx_state_nxt = S_START;
                    w_rx_timer_nxt = '0;
                end
            end
            S_START: begin
                if (r_rx_timer == c_half) begin
                    w_rx_timer_nxt = '0;
                    w_rx_bit_nxt   = '0;
                    // a start bit that has gone high again was a glitch
                    w_rx_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
                end else begin
                    w_rx_timer_nxt = r_rx_timer + 1'b1;
                end
            end
            S_DATA: begin
                if (r_rx_timer == c_last) begin
                    w_rx_timer_nxt = '0;
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == c_bit_last) begin
`ifdef UART_PARITY_EN
                        w_rx_state_nxt = S_PARITY;
`else
                        w_rx_state_nxt = S_STOP;
`endif
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_timer_nxt = r_rx_timer + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (r_rx_timer == c_last) begin
                    w_rx_timer_nxt = '0;
                    w_rx_par_nxt   = r_rx_sync;
                    w_rx_state_nxt = S_STOP;
                end else begin
                    w_rx_timer_nxt = r_rx_timer + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (r_rx_timer == c_last) begin
                    // leave at the sample point so a following start bit is seen in time
                    w_rx_timer_nxt = '0;
                    w_rx_state_nxt = S_IDLE;
`ifdef UART_PARITY_EN
                    w_rx_valid     = r_rx_sync & w_rx_par_ok;
                    w_rx_bad       = ~(r_rx_sync & w_rx_par_ok);
`else
                    w_rx_valid     = r_rx_sync;
                    w_rx_bad       = ~r_rx_sync;
`endif
                end else begin
                    w_rx_timer_nxt = r_rx_timer + 1'b1;
                end
            end
            default: begin
                w_rx_state_nxt = S_IDLE;
                w_rx_timer_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign w_full    = (r_count == c_full);
    assign w_can_pop = (r_count != '0) && !block;
    assign w_head    = r_mem[r_rd_ptr];
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign w_push    = w_rx_valid && (!w_full || w_pop);
    assign w_drop    = w_rx_valid && w_full && !w_pop;

    // Storage array; no reset needed, occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_rx_shift;
        end
    end

    // Wrap-around pointers and registered occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    // TX state register, shifter and registered serial line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= S_IDLE;
            r_tx_timer <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_timer <= w_tx_timer_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx       <= w_tx_line;
`ifdef UART_PARITY_EN
            r_tx_par   <= w_tx_par_nxt;
`endif
        end
    end

    // TX next state; the stop bit hands straight over to the next start bit when data waits
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_timer_nxt = r_tx_timer;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_pop          = 1'b0;
`ifdef UART_PARITY_EN
        w_tx_par_nxt   = r_tx_par;
`endif
        case (r_tx_state)
            S_IDLE: begin
                if (w_can_pop) begin
                    w_pop          = 1'b1;
                    w_tx_shift_nxt = w_head;
                    w_tx_timer_nxt = '0;
                    w_tx_state_nxt = S_START;
`ifdef UART_PARITY_EN
                    w_tx_par_nxt   = (^w_head) ^ c_odd;
`endif
                end
            end
            S_START: begin
                if (r_tx_timer == c_last) begin
                    w_tx_timer_nxt = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = S_DATA;
                end else begin
                    w_tx_timer_nxt = r_tx_timer + 1'b1;
                end
            end
            S_DATA: begin
                if (r_tx_timer == c_last) begin
                    w_tx_timer_nxt = '0;
                    w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                    if (r_tx_bit == c_bit_last) begin
`ifdef UART_PARITY_EN
                        w_tx_state_nxt = S_PARITY;
`else
                        w_tx_state_nxt = S_STOP;
`endif
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 1'b1;
                    end
                end else begin
                    w_tx_timer_nxt = r_tx_timer + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (r_tx_timer == c_last) begin
                    w_tx_timer_nxt = '0;
                    w_tx_state_nxt = S_STOP;
                end else begin
                    w_tx_timer_nxt = r_tx_timer + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (r_tx_timer == c_last) begin
                    w_tx_timer_nxt = '0;
                    if (w_can_pop) begin
                        w_pop          = 1'b1;
                        w_tx_shift_nxt = w_head;
                        w_tx_state_nxt = S_START;
`ifdef UART_PARITY_EN
                        w_tx_par_nxt   = (^w_head) ^ c_odd;
`endif
                    end else begin
                        w_tx_state_nxt = S_IDLE;
                    end
                end else begin
                    w_tx_timer_nxt = r_tx_timer + 1'b1;
                end
            end
            default: begin
                w_tx_state_nxt = S_IDLE;
                w_tx_timer_nxt = '0;
            end
        endcase
    end

    // Line level for the upcoming cycle, registered so tx is glitch-free
    always_comb begin
        w_tx_line = 1'b1;
        case (w_tx_state_nxt)
            S_START:  w_tx_line = 1'b0;
            S_DATA:   w_tx_line = w_tx_shift_nxt[0];
`ifdef UART_PARITY_EN
            S_PARITY: w_tx_line = w_tx_par_nxt;
`endif
            default:  w_tx_line = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Status: last good character and sticky error flags (set wins over clear)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led       <= '0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_rx_valid) begin
                r_led <= r_rx_shift;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_err) begin
                r_overflow <= 1'b0;
            end
            if (w_rx_bad) begin
                r_frame_err <= 1'b1;
            end else if (clear_err) begin
                r_frame_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_loopback.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_loopback
// Brief    : Directed self-checking bench for uart_fifo_loopback
//            (CLK_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=16, even parity when
//            UART_PARITY_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_loopback;

    localparam int CPB = 4;
    localparam int DB  = 8;
    localparam int FD  = 16;
`ifdef UART_PARITY_EN
    localparam int NB  = DB + 3;
`else
    localparam int NB  = DB + 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          tx;
    logic          block = 1'b0;
    logic          clear_err = 1'b0;
    logic [DB-1:0] led;
    logic [4:0]    fifo_count;
    logic          overflow;
    logic          frame_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          par;
        logic          ok;
    } frame_t;

    frame_t mon_q[$];

    uart_fifo_loopback #(
        .CLK_PER_BIT (CPB),
        .DATA_BITS   (DB),
        .FIFO_DEPTH  (FD),
        .ODD_PARITY  (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .tx         (tx),
        .block      (block),
        .clear_err  (clear_err),
        .led        (led),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // tx decoder: samples every cycle on the falling edge, each bit must be CPB identical samples
    initial begin : g_tx_monitor
        logic [NB-1:0] v;
        logic          uni;
        frame_t        f;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                uni = 1'b1;
                v   = '0;
                for (int b = 0; b < NB; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (c == 0) v[b] = tx;
                        else if (tx !== v[b]) uni = 1'b0;
                    end
                end
                f.data = v[DB:1];
`ifdef UART_PARITY_EN
                f.par  = v[DB+1];
`else
                f.par  = 1'b0;
`endif
                f.ok   = uni && (v[0] == 1'b0) && (v[NB-1] == 1'b1);
                mon_q.push_back(f);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [DB-1:0] d, input logic stop_bit, input logic par_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            tick(CPB);
        end
`ifdef UART_PARITY_EN
        rx = par_bit;
        tick(CPB);
`else
        if (par_bit === 1'bx) rx = 1'b1;
`endif
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int limit, input string tag);
        int cyc;
        cyc = 0;
        while (mon_q.size() < n && cyc < limit) begin
            tick(1);
            cyc++;
        end
        check(tag, mon_q.size(), n);
    endtask

    initial begin : g_main
        frame_t f;
        int     cyc;

        // ---------------- reset state ----------------
        tick(3);
        check("rst_tx", tx, 1);
        check("rst_led", led, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ferr", frame_err, 0);
        rst_n = 1'b1;
        tick(3);

        // ---------------- single echo of 0xA5 ----------------
        send_char(8'hA5, 1'b1, ^8'hA5);
        wait_frames(1, 200, "a5_timeout");
        f = mon_q.pop_front();
        check("a5_data", f.data, 8'hA5);
        check("a5_frame", f.ok, 1);
`ifdef UART_PARITY_EN
        check("a5_par", f.par, 0);
`endif
        check("a5_led", led, 8'hA5);
        check("a5_count", fifo_count, 0);
        check("a5_ovf", overflow, 0);
        check("a5_ferr", frame_err, 0);

        // ---------------- burst into a blocked FIFO ----------------
        block = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            send_char(8'(i), 1'b1, ^8'(i));
        end
        tick(6);
        check("burst_count", fifo_count, 16);
        check("burst_tx_idle", tx, 1);
        check("burst_none_sent", mon_q.size(), 0);
        check("burst_ovf_clear", overflow, 0);
        send_char(8'h11, 1'b1, ^8'h11);
        tick(6);
        check("ovf_set", overflow, 1);
        check("ovf_count", fifo_count, 16);
        check("ovf_led", led, 8'h11);
        block = 1'b0;
        wait_frames(16, 16 * NB * CPB + 200, "drain_timeout");
        for (int i = 1; i <= 16; i++) begin
            if (mon_q.size() > 0) begin
                f = mon_q.pop_front();
                check($sformatf("drain_data_%0d", i), f.data, 32'(i));
                check($sformatf("drain_frame_%0d", i), f.ok, 1);
            end
        end
        tick(100);
        check("drain_no_0x11", mon_q.size(), 0);
        check("drain_count", fifo_count, 0);
        check("drain_tx_idle", tx, 1);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("ovf_cleared", overflow, 0);

        // ---------------- bad stop bit ----------------
        send_char(8'h3C, 1'b0, ^8'h3C);
        tick(6);
        check("ferr_set", frame_err, 1);
        check("ferr_led", led, 8'h11);
        check("ferr_count", fifo_count, 0);
        tick(60);
        check("ferr_none_sent", mon_q.size(), 0);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("ferr_cleared", frame_err, 0);

        // ---------------- one-cycle rx glitch ----------------
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(60);
        check("glitch_ferr", frame_err, 0);
        check("glitch_ovf", overflow, 0);
        check("glitch_count", fifo_count, 0);
        check("glitch_led", led, 8'h11);
        check("glitch_tx", tx, 1);
        check("glitch_none_sent", mon_q.size(), 0);

        // ---------------- reset in the middle of a tx frame ----------------
        block = 1'b1;
        send_char(8'h0F, 1'b1, ^8'h0F);
        send_char(8'h33, 1'b1, ^8'h33);
        tick(6);
        check("mid_count", fifo_count, 2);
        block = 1'b0;
        cyc = 0;
        while (tx !== 1'b0 && cyc < 50) begin
            tick(1);
            cyc++;
        end
        check("mid_start", tx, 0);
        tick(21);
        check("mid_bit4", tx, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_led", led, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(60);
        mon_q.delete();
        tick(100);
        check("mid_no_residual", mon_q.size(), 0);
        check("mid_tx_idle", tx, 1);
        check("mid_count_after", fifo_count, 0);

`ifdef UART_PARITY_EN
        // ---------------- parity ----------------
        send_char(8'h07, 1'b1, 1'b1);
        wait_frames(1, 200, "par_timeout");
        if (mon_q.size() > 0) begin
            f = mon_q.pop_front();
            check("par_data", f.data, 8'h07);
            check("par_bit", f.par, 1);
            check("par_frame", f.ok, 1);
        end
        check("par_good_ferr", frame_err, 0);
        send_char(8'h07, 1'b1, 1'b0);
        tick(60);
        check("par_bad_ferr", frame_err, 1);
        check("par_bad_dropped", mon_q.size(), 0);
        check("par_bad_count", fifo_count, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_fifo_loopback.md
Name: uart_fifo_loopback

Overview:
- Parametrised UART echo engine: serial receiver, synchronous FIFO and serial transmitter in one block.
- Every correctly framed character received on rx is buffered and retransmitted on tx; last good character drives led.
- Adds burst buffering, flow stall, error flags and selectable width over the plain rx→tx echo top level.

Parameters:
- CLK_PER_BIT, 4, clk cycles per bit (≥4); e.g. 50 MHz/12 Mbaud → 4, 50 MHz/115200 → 434.
- DATA_BITS, 8, data bits per frame (5..9).
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥2.
- ODD_PARITY, 0, parity sense when UART_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  serial input, idle high, asynchronous to clk
- tx  out  1  serial output, idle high
- block  in  1  1 = do not start a new tx frame; a frame in flight completes
- clear_err  in  1  synchronous clear of sticky flags
- led  out  DATA_BITS  last correctly received character
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: character dropped because FIFO was full
- frame_err  out  1  sticky: stop bit (or parity) bad

Behaviour:
- Reset (rst_n low, async): tx=1, led=0, fifo_count=0, overflow=0, frame_err=0, both FSMs IDLE, pointers 0. Reset mid-frame abandons both frames; tx goes high immediately.
- rx passes a 2-flop synchroniser (initialised to 1) before any use; 2-cycle input latency.
- RX FSM IDLE→START→DATA→[PARITY]→STOP→IDLE, driven by a bit-timer counting 0..CLK_PER_BIT-1.
- IDLE: synced rx=0 → START, timer cleared.
- START: at CLK_PER_BIT/2 (integer division) resample; rx=1 → IDLE (glitch, no flags); rx=0 → DATA, timer cleared.
- DATA: sample every CLK_PER_BIT cycles (mid-bit), LSB first, DATA_BITS samples.
- STOP: sample mid-bit. 1 → character valid; 0 → frame_err=1, character discarded, led unchanged. Return to IDLE at the stop-bit sample point, so back-to-back frames are accepted.
- Valid character: led updated the following cycle. Pushed to the FIFO if not full; if full, dropped and overflow=1.
- FIFO: DEPTH entries, wrap-around pointers of $clog2(DEPTH) bits. Full = count==DEPTH; empty = count==0. Push and pop in the same cycle → count unchanged, both pointers advance; legal also when full, since pop frees a slot first.
- TX FSM IDLE→START→DATA→[PARITY]→STOP→IDLE.
- IDLE: when FIFO not empty and block=0, pop the head into a shift register and enter START.
- Each bit is held exactly CLK_PER_BIT cycles: start 0, data LSB first, stop 1.
- After STOP: returns to IDLE, may pop the next character the same cycle, giving back-to-back frames with no extra idle.
- Latency: a character pushed at cycle N with TX idle and block=0 is popped at N+1; tx falls to the start bit at N+2.
- block asserted mid-frame has no effect until the frame's stop bit ends.
- Sticky flags: set by events; cleared only by clear_err. Set and clear in the same cycle → flag stays 1.
- fifo_count is registered and reflects pushes/pops of the previous cycle.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: one parity bit follows the data on both rx and tx (even parity if ODD_PARITY=0, odd parity if 1). tx computes parity over the popped character. rx checks parity; a mismatch sets frame_err and discards the character, exactly as a bad stop bit does. Frame = DATA_BITS+3 bits.
- Undefined: no parity state, no parity logic. Frame = DATA_BITS+2 bits; ODD_PARITY unused.

Test Plan:
- Reset, CLK_PER_BIT=4, DATA_BITS=8: send 0xA5 on rx → led=0xA5; tx emits start, 1,0,1,0,0,1,0,1, stop, each 4 cycles (40 cycles total); fifo_count returns to 0; no flags set.
- Hold block=1, send 0x01..0x10 back-to-back (16 chars) → fifo_count=16, tx stays 1. Send 0x11 → overflow=1, fifo_count stays 16. Release block → tx emits 0x01..0x10 in order; 0x11 never sent.
- Frame 0x3C with stop bit forced 0 → frame_err=1, led unchanged, nothing transmitted. Pulse clear_err → frame_err=0.
- rx low pulse of 1 cycle while idle → no state change, no flags, tx idle.
- Assert rst_n=0 at the 5th data bit of a tx frame → tx=1 within the same cycle; after release the FIFO is empty and no residual frame is transmitted.
- With UART_PARITY_EN and ODD_PARITY=0: send 0x07 with parity bit 1 → echoed with parity bit 1. Send 0x07 with parity bit 0 → frame_err=1 and the character is dropped.
